lab_io_dram: RTL
================

// Module: lab_io_dram
// PURPOSE
//   Parametrised data memory with memory-mapped I/O for the single-cycle CPU. Replaces the fixed
//   8-bit, 2-in/6-out data RAM and adds four things: configurable port counts, two-flop input
//   synchronisers, per-bit sticky change flags (clear-on-read or write-1-to-clear) and a post-reset
//   arming counter. Sits between the CPU data bus (ADDR=DataD, DATA=DataB, Q=Din) and board I/O.
// PARAMETERS
//   DW       8      data width of RAM words and all I/O ports
//   AW       8      address width
//   N_IN     2      number of input ports (IN packs N_IN*DW bits, port 0 in LSBs)
//   N_OUT    6      number of output ports (OUT packs N_OUT*DW bits, port 0 in LSBs)
//   IO_BASE  'hF0   first I/O address; RAM occupies 0..IO_BASE-1; legal if IO_BASE+2*N_IN+N_OUT <= 2**AW
// PORTS
//   CLK    in   1           system clock; all state updates on rising edge
//   RESET  in   1           synchronous, active-high reset
//   ADDR   in   AW          word address
//   DATA   in   DW          write data
//   MW     in   1           memory write enable
//   RE     in   1           read strobe; qualifies flag clear-on-read
//   Q      out  DW          read data, combinational from ADDR (zero-cycle read latency)
//   IN     in   N_IN*DW     asynchronous board inputs
//   OUT    out  N_OUT*DW    registered output ports
// BEHAVIOUR
//   Address map (i = input index, j = output index):
//     IO_BASE+i          IN_DATA[i]   synchronised input, read-only
//     IO_BASE+N_IN+i     FLAG[i]      sticky per-bit change flags; read clears, write-1 clears
//     IO_BASE+2*N_IN+j   OUT[j]       read/write output register
//     all other I/O addresses: reads return 0, writes ignored
//   RAM: MW=1 with ADDR<IO_BASE writes DATA at the edge. Q shows the pre-write word during the
//     write cycle. RESET does not alter RAM contents.
//   Sync: s1<=IN, s2<=s1, s3<=s2 each edge. IN_DATA=s2.
//     A change of IN sampled at edge k is visible in Q after edge k+1.
//   Arm counter arm_cnt (2 bits): RESET -> 0; then increments each edge, saturating at 3.
//     Flags are never set while arm_cnt!=3, which blocks spurious edges from zeroed sync flops.
//   Flag update per edge, with chg = s2^s3 and arm = (arm_cnt==3):
//     clr = (RE && !MW && ADDR==flag addr) ? all-ones : (MW && ADDR==flag addr) ? DATA : 0
//     FLAG <= (FLAG & ~clr) | (arm ? chg : 0)
//     A set always beats a clear in the same cycle, so no edge is lost.
//     A change sampled at edge k sets its FLAG bit after edge k+2.
//   Read-clear is edge-qualified: a held ADDR with RE=1 clears once per edge.
//     Edges arriving meanwhile re-set the flag.
//   OUT[j]: MW=1 with ADDR matching loads DATA at the edge.
//   Writes to IN_DATA addresses are ignored. MW and RE together: treated as a write (no read-clear).
//   Reset values: OUT=0, FLAG=0, s1/s2/s3=0, arm_cnt=0. Q follows ADDR at all times.
//   RESET mid-operation: all I/O state returns to reset values at that edge and the arming
//     sequence restarts. RAM is untouched.
//   Address arithmetic is unsigned AW-bit; no wrap beyond 2**AW-1.
// TESTING
//   1 Default params: RESET 1 cycle with IN=16'hA55A; hold 5 cycles -> FLAG0=FLAG1=0,
//     Q@F0=8'h5A, Q@F1=8'hA5.
//   2 After arming, flip IN[3:0] 0->F at edge k -> Q@F0 changes after k+1; FLAG0=8'h0F after k+2.
//     Read F2 with RE=1 -> next cycle FLAG0=0.
//   3 FLAG0=8'hFF; MW=1 ADDR=F2 DATA=8'h0F -> FLAG0=8'hF0. In the same cycle a bit-0 change
//     arrives (chg=1) -> FLAG0=8'hF1 (set wins).
//   4 Write 8'h3C to F4..F9 one per cycle -> OUT=48'h3C3C3C3C3C3C. Write F0 with 8'hFF ->
//     IN_DATA unchanged. Read FA..FF -> 0.
//   5 Write RAM[8'h10]=8'h77 -> Q@10 in the write cycle shows the old value, 8'h77 after.
//     RESET -> RAM[10] still 8'h77, OUT=0.
//   6 Params DW=16, N_IN=4, N_OUT=4, IO_BASE='hE0: rerun 1-4 at the remapped addresses
//     (flags E4..E7, outputs E8..EB).

Source files
------------

// File: rtl/lab_io_dram.sv
// Data RAM with memory-mapped I/O: synchronised inputs, sticky per-bit change flags,
// registered output ports and a post-reset arming counter that masks start-up edges.
module lab_io_dram #(
  parameter int          DW      = 8,
  parameter int          AW      = 8,
  parameter int          N_IN    = 2,
  parameter int          N_OUT   = 6,
  parameter int unsigned IO_BASE = 'hF0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [AW-1:0]         ADDR,
  input  logic [DW-1:0]         DATA,
  input  logic                  MW,
  input  logic                  RE,
  output logic [DW-1:0]         Q,
  input  logic [N_IN*DW-1:0]    IN,
  output logic [N_OUT*DW-1:0]   OUT
);

  localparam logic [AW-1:0] L_BASE = AW'(IO_BASE);

  logic [DW-1:0]      r_mem  [IO_BASE];
  logic [N_IN*DW-1:0] r_s1, r_s2, r_s3;
  logic [1:0]         r_arm_cnt;
  logic [DW-1:0]      r_flag [N_IN];
  logic [DW-1:0]      r_out  [N_OUT];

  logic [N_IN*DW-1:0] w_chg;
  logic [DW-1:0]      w_clr  [N_IN];
  logic               w_arm;
  logic               w_ram_sel;

  assign w_chg     = r_s2 ^ r_s3;
  assign w_arm     = (r_arm_cnt == 2'd3);
  assign w_ram_sel = (ADDR < L_BASE);

  // NOTE: RAM contents are deliberately left out of the reset; only I/O state is reset.
  always_ff @(posedge CLK) begin
    if (MW && w_ram_sel) r_mem[ADDR] <= DATA;
  end

  // Write takes priority over read-clear when MW and RE are both asserted.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      w_clr[i] = '0;
      if (ADDR == L_BASE + AW'(N_IN + i)) begin
        if (MW)      w_clr[i] = DATA;
        else if (RE) w_clr[i] = '1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_s3      <= '0;
      r_arm_cnt <= '0;
      for (int i = 0; i < N_IN; i++)  r_flag[i] <= '0;
      for (int j = 0; j < N_OUT; j++) r_out[j]  <= '0;
    end else begin
      r_s1 <= IN;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (!w_arm) r_arm_cnt <= r_arm_cnt + 2'd1;
      // Set is OR-ed after the clear so a same-cycle edge is never lost.
      for (int i = 0; i < N_IN; i++)
        r_flag[i] <= (r_flag[i] & ~w_clr[i]) | (w_arm ? w_chg[i*DW +: DW] : '0);
      for (int j = 0; j < N_OUT; j++)
        if (MW && ADDR == L_BASE + AW'(2*N_IN + j)) r_out[j] <= DATA;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    Q = '0;
    if (w_ram_sel) begin
      Q = r_mem[ADDR];
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (ADDR == L_BASE + AW'(i))        Q = r_s2[i*DW +: DW];
        if (ADDR == L_BASE + AW'(N_IN + i)) Q = r_flag[i];
      end
      for (int j = 0; j < N_OUT; j++)
        if (ADDR == L_BASE + AW'(2*N_IN + j)) Q = r_out[j];
    end
  end

  always_comb begin
    OUT = '0;
    for (int j = 0; j < N_OUT; j++) OUT[j*DW +: DW] = r_out[j];
  end

endmodule
